// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the SRAM.
// The arbiter uses the slave view; requesters and the SRAM side use master.
interface sram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_ack;
  logic          inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ack;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wen, data_addr, data_wdata,
    input  sram_rdata,
    output inst_ack, inst_rvalid, inst_rdata,
    output data_ack, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wen, data_addr, data_wdata,
    output sram_rdata,
    input  inst_ack, inst_rvalid, inst_rdata,
    input  data_ack, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data has priority, fetch gets a forced grant
// after STARVE_LIMIT consecutive denied cycles.
module sram_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  sram_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

  typedef enum logic {
    PRI_DATA,
    PRI_INST
  } pri_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } own_e;

  pri_e          state;
  own_e          resp_owner;
  logic [CW-1:0] starve_cnt;
  logic          inst_gnt;
  logic          data_gnt;
  logic          inst_denied;
  logic          data_read;

  // Grants are combinational; nothing is granted while reset is held.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (resetn) begin
      priority case (1'b1)
        (state == PRI_INST) && bus.inst_req: inst_gnt = 1'b1;
        bus.data_req:                        data_gnt = 1'b1;
        bus.inst_req:                        inst_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign inst_denied = bus.inst_req && !inst_gnt;
  assign data_read   = data_gnt && (bus.data_wen == 4'b0000);

  always_comb begin
    bus.sram_en    = inst_gnt || data_gnt;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    priority case (1'b1)
      data_gnt: begin
        bus.sram_wen   = bus.data_wen;
        bus.sram_addr  = bus.data_addr;
        bus.sram_wdata = bus.data_wdata;
      end
      inst_gnt: bus.sram_addr = bus.inst_addr;
      default: ;
    endcase
  end

  assign bus.inst_ack    = inst_gnt;
  assign bus.data_ack    = data_gnt;
  assign bus.inst_rvalid = (resp_owner == OWN_INST);
  assign bus.data_rvalid = (resp_owner == OWN_DATA);
  assign bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : '0;
  assign bus.data_rdata  = bus.data_rvalid ? bus.sram_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= PRI_DATA;
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
    end else begin
      if (inst_denied) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      unique case (state)
        PRI_DATA: if (inst_denied && starve_cnt == CNT_LAST) state <= PRI_INST;
        PRI_INST: if (inst_gnt) state <= PRI_DATA;
        default:  state <= PRI_DATA;
      endcase

      priority case (1'b1)
        inst_gnt:  resp_owner <= OWN_INST;
        data_read: resp_owner <= OWN_DATA;
        default:   resp_owner <= OWN_NONE;
      endcase
    end
  end

endmodule
